freq_gate_controller: RTL and testbench

- Timing-control master for the cascaded modulo counters of the frequency meter.
- Generates the gate window (En), the counter clear (Clear, active-low), the result latch pulse (Store) and the 2-bit status code (Status_Value) that the counters sample on the rising edge of En.
- Performs auto-ranging: it picks one of three gate lengths from the overflow and leading-zero feedback of the counter chain.

---
 rtl/freq_gate_controller.sv | 138 +++++++++++++
 tb/tb_freq_gate_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_controller.sv
// Gate/clear/store sequencer with auto-ranging for the frequency meter counter chain.
// Latency: outputs decode the registered state, so each phase is visible the cycle after the edge that entered it.
// Backpressure: none; Run is sampled only in IDLE and at the end of DISPLAY, so a started measurement always completes.
module freq_gate_controller #(
  parameter int GATE0       = 1000,
  parameter int GATE1       = 100,
  parameter int GATE2       = 10,
  parameter int DISP_CYCLES = 500,
  parameter int CW          = 16
) (
  input  logic       CP,
  input  logic       nRST,
  input  logic       Run,
  input  logic       Overflow,
  input  logic       Msd_Zero,
  output logic       En,
  output logic       Clear,
  output logic       Store,
  output logic [1:0] Status_Value,
  output logic [1:0] Range,
  output logic       Over_range
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ARM,
    S_GATE,
    S_HOLD,
    S_STORE,
    S_DISP
  } state_t;

  localparam logic [CW-1:0] GATE0_LAST = CW'(GATE0 - 1);
  localparam logic [CW-1:0] GATE1_LAST = CW'(GATE1 - 1);
  localparam logic [CW-1:0] GATE2_LAST = CW'(GATE2 - 1);
  localparam logic [CW-1:0] DISP_LAST  = CW'(DISP_CYCLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] gate_last;
  logic          ovf_flag;

  // Gate length follows Range, which only moves when leaving STORE, so it is constant across a gate.
  always_comb begin
    gate_last = GATE2_LAST;
    case (Range)
      2'd0:    gate_last = GATE0_LAST;
      2'd1:    gate_last = GATE1_LAST;
      default: gate_last = GATE2_LAST;
    endcase
  end

  // Next-state logic for the measurement sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Run) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_ARM;
      S_ARM:   state_nxt = S_GATE;
      S_GATE:  if (cnt == gate_last) state_nxt = S_HOLD;
      S_HOLD:  state_nxt = S_STORE;
      S_STORE: state_nxt = S_DISP;
      S_DISP:  if (cnt == DISP_LAST) state_nxt = Run ? S_CLEAR : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CP or negedge nRST) begin
    if (!nRST) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Phase cycle counter: restarts on every state change, only advances in the multi-cycle phases.
  always_ff @(posedge CP or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if (state == S_GATE || state == S_DISP) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Overflow seen during the gate; cleared at the start of each measurement.
  always_ff @(posedge CP or negedge nRST) begin
    if (!nRST) begin
      ovf_flag <= 1'b0;
    end else if (state == S_CLEAR) begin
      ovf_flag <= 1'b0;
    end else if (state == S_GATE && Overflow) begin
      ovf_flag <= 1'b1;
    end
  end

  // Auto-ranging on the edge that leaves STORE; overflow takes priority over the leading-zero hint.
  always_ff @(posedge CP or negedge nRST) begin
    if (!nRST) begin
      Range      <= 2'd0;
      Over_range <= 1'b0;
    end else if (state == S_STORE) begin
      if (ovf_flag) begin
        if (Range < 2'd2) Range <= Range + 2'd1;
        else              Over_range <= 1'b1;
      end else begin
        Over_range <= 1'b0;
        if (Msd_Zero && Range != 2'd0) Range <= Range - 2'd1;
      end
    end
  end

  // Output decode purely from the registered state.
  always_comb begin
    En           = 1'b0;
    Clear        = 1'b1;
    Store        = 1'b0;
    Status_Value = 2'b00;
    case (state)
      S_CLEAR: begin
        Clear        = 1'b0;
        Status_Value = 2'b10;
      end
      S_ARM:   Status_Value = 2'b11;
      S_GATE: begin
        En           = 1'b1;
        Status_Value = 2'b11;
      end
      S_STORE: begin
        Store        = 1'b1;
        Status_Value = 2'b01;
      end
      default: Status_Value = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_freq_gate_controller.sv
// Bench for freq_gate_controller: timeline-offset reference model plus directed range/reset scenarios.
// Inputs change on the falling edge; outputs are compared on the falling edge every cycle.
module tb_freq_gate_controller;

  localparam int G0 = 20;
  localparam int G1 = 8;
  localparam int G2 = 4;
  localparam int DC = 5;

  logic       CP = 1'b0;
  logic       nRST = 1'b0;
  logic       Run = 1'b0;
  logic       Overflow = 1'b0;
  logic       Msd_Zero = 1'b0;
  logic       En;
  logic       Clear;
  logic       Store;
  logic [1:0] Status_Value;
  logic [1:0] Range;
  logic       Over_range;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int clear_cnt = 0;

  freq_gate_controller #(
    .GATE0(G0), .GATE1(G1), .GATE2(G2), .DISP_CYCLES(DC), .CW(16)
  ) dut (
    .CP(CP), .nRST(nRST), .Run(Run), .Overflow(Overflow), .Msd_Zero(Msd_Zero),
    .En(En), .Clear(Clear), .Store(Store), .Status_Value(Status_Value),
    .Range(Range), .Over_range(Over_range)
  );

  always #5 CP = ~CP;

  always @(posedge CP) cyc++;

  always @(negedge CP) if (!Clear) clear_cnt++;

  // Reference model: a measurement is a timeline indexed by offset t from CLEAR entry.
  bit m_act = 0;
  int m_t = 0;
  int m_g = G0;
  int m_r = 0;
  bit m_ov = 0;
  bit m_flag = 0;

  function automatic int glen(input int r);
    return (r == 0) ? G0 : (r == 1) ? G1 : G2;
  endfunction

  always @(posedge CP or negedge nRST) begin
    if (!nRST) begin
      m_act = 0; m_t = 0; m_r = 0; m_ov = 0; m_flag = 0; m_g = G0;
    end else if (!m_act) begin
      if (Run) begin m_act = 1; m_t = 0; m_g = glen(m_r); end
    end else begin
      if (m_t == 0) m_flag = 0;
      if (m_t >= 2 && m_t < 2 + m_g && Overflow) m_flag = 1;
      if (m_t == m_g + 3) begin
        if (m_flag) begin
          if (m_r < 2) m_r++; else m_ov = 1;
        end else begin
          m_ov = 0;
          if (Msd_Zero && m_r > 0) m_r--;
        end
      end
      if (m_t == m_g + 3 + DC) begin
        if (Run) begin m_t = 0; m_g = glen(m_r); end
        else m_act = 0;
      end else begin
        m_t++;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge CP) begin
    logic e_en, e_clr, e_st;
    int   e_stat;
    e_en = 0; e_clr = 1; e_st = 0; e_stat = 0;
    if (m_act) begin
      if (m_t == 0) begin e_clr = 0; e_stat = 2; end
      else if (m_t == 1) e_stat = 3;
      else if (m_t <= m_g + 1) begin e_stat = 3; e_en = 1; end
      else if (m_t == m_g + 3) begin e_st = 1; e_stat = 1; end
    end
    total++;
    if (En !== e_en || Clear !== e_clr || Store !== e_st || int'(Status_Value) != e_stat ||
        int'(Range) != m_r || Over_range !== m_ov || $isunknown(Status_Value) || $isunknown(Range)) begin
      bad++;
      $display("FAIL model cyc=%0d got En=%b Clr=%b St=%b Stat=%0d Rng=%0d Ovr=%b want En=%b Clr=%b St=%b Stat=%0d Rng=%0d Ovr=%b",
               cyc, En, Clear, Store, Status_Value, Range, Over_range, e_en, e_clr, e_st, e_stat, m_r, m_ov);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CP);
  endtask

  // which: 0 = En, 1 = Store, 2 = Clear
  task automatic wait_sig(input int which, input logic v, input string nm);
    logic s;
    for (int n = 0; n < 400; n++) begin
      @(negedge CP);
      s = (which == 0) ? En : (which == 1) ? Store : Clear;
      if (s === v) return;
    end
    total++; bad++;
    $display("FAIL wait_%s timed out", nm);
  endtask

  // Measures the next En window; optionally pulses Overflow for one cycle inside it.
  task automatic gate_len(input bit pulse, output int len);
    wait_sig(0, 1'b1, "en_rise");
    len = 1;
    while (len < 400) begin
      @(negedge CP);
      if (!En) break;
      len++;
      Overflow = pulse && (len == 3);
    end
    Overflow = 0;
  endtask

  initial begin
    int len;
    int c1;
    int c2;
    int clr_ref;

    step(3);
    chk("rst_en", En, 0);
    chk("rst_clear", Clear, 1);
    chk("rst_store", Store, 0);
    chk("rst_status", Status_Value, 0);
    chk("rst_range", Range, 0);
    chk("rst_over", Over_range, 0);

    nRST = 1; Run = 1;
    wait_sig(2, 1'b0, "clear1");
    c1 = cyc;
    gate_len(0, len);
    chk("gate_r0_len", len, 20);
    wait_sig(2, 1'b0, "clear2");
    c2 = cyc;
    chk("clear_period", c2 - c1, 29);

    gate_len(1, len);
    chk("gate_r0_ovf_len", len, 20);
    wait_sig(1, 1'b1, "store_a");
    step(1);
    chk("range_up_1", Range, 1);

    gate_len(1, len);
    chk("gate_r1_len", len, 8);
    wait_sig(1, 1'b1, "store_b");
    step(1);
    chk("range_up_2", Range, 2);

    gate_len(1, len);
    chk("gate_r2_len", len, 4);
    wait_sig(1, 1'b1, "store_c");
    step(1);
    chk("range_sat", Range, 2);
    chk("over_range_set", Over_range, 1);

    Msd_Zero = 1;
    gate_len(0, len);
    chk("gate_r2_len_b", len, 4);
    wait_sig(1, 1'b1, "store_d");
    step(1);
    chk("range_down", Range, 1);
    chk("over_range_clr", Over_range, 0);

    gate_len(1, len);
    chk("gate_r1_len_b", len, 8);
    wait_sig(1, 1'b1, "store_e");
    step(1);
    chk("ovf_priority", Range, 2);
    Msd_Zero = 0;

    wait_sig(0, 1'b1, "en_stop");
    step(2);
    Run = 0;
    wait_sig(1, 1'b1, "store_stop");
    clr_ref = clear_cnt;
    step(40);
    chk("no_clear_after_stop", clear_cnt - clr_ref, 0);
    chk("idle_status", Status_Value, 0);

    Run = 1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge CP);
      Overflow = ($urandom_range(0, 7) == 0);
      Msd_Zero = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 99) == 0) Run = ~Run;
    end
    Overflow = 0; Msd_Zero = 0; Run = 1;

    wait_sig(0, 1'b1, "en_rst");
    step(2);
    #3 nRST = 0;
    #1;
    chk("async_rst_en", En, 0);
    chk("async_rst_status", Status_Value, 0);
    chk("async_rst_range", Range, 0);
    step(2);
    nRST = 1;
    wait_sig(2, 1'b0, "clear_after_rst");
    gate_len(0, len);
    chk("gate_after_rst", len, 20);
    step(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
